mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main controller for the MIPS-subset datapath. Consumes `opcode`/`funct` from the datapath's instruction register. Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, driving the datapath's mux selects and write enables one phase per cycle. Replaces the single-cycle combinational decoder so the datapath can share one memory port and register its internal results between phases.

## Interface
Parameters:
- `PC_INC_EN_FETCH`, default 1: 1 = PC+4 written in FETCH; 0 = `pc_write` suppressed in FETCH (debug single-step hold).

Ports:
- `clk`  in  1: rising-edge clock
- `rst`  in  1: synchronous, active-high reset
- `opcode`  in  6: instr[31:26] from datapath IR
- `funct`  in  6: instr[5:0] from datapath IR
- `zero`  in  1: ALU zero flag, valid in BRANCH state
- `ir_write`  out  1: load IR from instruction memory
- `pc_write`  out  1: load PC with next-PC
- `npc_sel`  out  1: 0 = PC+4, 1 = branch target
- `j_ctl`  out  1: 1 = jump target
- `alu_ctl`  out  2: 00 addu, 01 subu, 10 or, 11 unused
- `alu_src`  out  1: 0 = rs2 data, 1 = extended immediate
- `ext_op`  out  2: 00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
- `reg_dst`  out  1: 0 = rt, 1 = rd
- `reg_src`  out  2: 00 ALU, 01 DM, 10 ext
- `reg_write`  out  1: GPR write enable
- `mem_write`  out  1: DM write enable
- `ins_done`  out  1: one-cycle pulse in last state of each instruction
- `illegal`  out  1: sticky, set on undecodable instruction

## Operation
- Supported instructions: R-type (opcode 000000) addu (funct 100001), subu (100011); ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010.
- `opcode`/`funct` are latched into internal registers in DECODE. All later states decode from the latched copy only.
- States and transitions:
  - FETCH: `ir_write`=1, `pc_write`=PC_INC_EN_FETCH, npc_sel=0. Next state DECODE.
  - DECODE: no enables. Next state: EXE for R/ori/lw/sw; WB for lui; BRANCH for beq; JUMP for j; FETCH for anything else, with `illegal` set.
  - EXE: alu_src=1 for ori/lw/sw, else 0. alu_ctl: add for lw/sw/addu, sub for subu, or for ori. ext_op: 01 for lw/sw, 00 for ori. Next state MEM for lw/sw, else WB.
  - MEM: lw: mem_write=0, next WB. sw: mem_write=1, ins_done=1, next FETCH.
  - WB: reg_write=1. reg_dst=1 only for R-type. reg_src: 01 for lw, 10 for lui (ext_op=10), else 00. ins_done=1. Next FETCH.
  - BRANCH: alu_ctl=01, alu_src=0. pc_write=`zero`, npc_sel=1, ext_op=01. ins_done=1. Next FETCH.
  - JUMP: pc_write=1, j_ctl=1, ins_done=1. Next FETCH.
- Any output not listed for a state is 0.
- Unknown funct under opcode 000000 is treated as illegal.
- `illegal` stays set until `rst`.

## Timing
- Outputs are Moore: a function of the state register and the latched opcode/funct only. They are valid the whole cycle and have no combinational path from `opcode`, `funct` or `zero`. The one exception is `pc_write` in BRANCH, which follows `zero` combinationally.
- Cycles per instruction: R/ori 4, lw 5, sw 4, lui 3, beq 3, j 3, illegal 2.
- While `rst`=1: state forced to FETCH, latched op cleared to 0, `illegal`=0, and all outputs held 0 (including `ir_write` and `pc_write`).
- The first FETCH executes in the first cycle after `rst` falls.
- `rst` asserted in any state aborts the instruction at that edge. No partial write occurs in the reset cycle.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - Adds outputs `cycle_cnt` [31:0] and `instr_cnt` [31:0], both cleared by `rst`.
  - `cycle_cnt` increments every non-reset cycle. `instr_cnt` increments on each `ins_done`.
  - Both wrap from 0xFFFFFFFF to 0.
- Not defined: the ports and counters are absent.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0. On the first cycle after release: `ir_write`=1, `pc_write`=1.
- addu (opcode 0, funct 100001) → FETCH, DECODE, EXE (alu_ctl=00, alu_src=0), WB (reg_write=1, reg_dst=1, reg_src=00). `ins_done` in cycle 4.
- lw then sw → lw takes 5 cycles with reg_src=01 in WB. sw takes 4 cycles with mem_write=1 only in the MEM cycle. ext_op=01 in EXE for both.
- beq with zero=1 → pc_write=1, npc_sel=1 in cycle 3. With zero=0 → pc_write=0. Both return to FETCH.
- Opcode 111111 → `illegal` rises after DECODE, FETCH follows, and `illegal` stays high until `rst`.
- Assert `rst` during a lw MEM state → no reg_write occurs, the next cycle after release is FETCH, and (with MC_CTRL_PERF_EN) both counters read 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-subset datapath (FETCH/DECODE/EXE/MEM/WB/BRANCH/JUMP).
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl #(
  parameter int unsigned PC_INC_EN_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic        npc_sel,
  output logic        j_ctl,
  output logic [1:0]  alu_ctl,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic        reg_dst,
  output logic [1:0]  reg_src,
  output logic        reg_write,
  output logic        mem_write,
  output logic        ins_done,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_BRANCH, S_JUMP
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  logic       r_illegal;
  logic       w_illegal_set;

  logic w_is_r, w_is_subu, w_is_ori, w_is_lw, w_is_sw, w_is_lui;

  // Post-DECODE states see only the latched instruction fields
  assign w_is_r    = (r_op == OP_RTYPE);
  assign w_is_subu = w_is_r && (r_funct == FN_SUBU);
  assign w_is_ori  = (r_op == OP_ORI);
  assign w_is_lw   = (r_op == OP_LW);
  assign w_is_sw   = (r_op == OP_SW);
  assign w_is_lui  = (r_op == OP_LUI);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= 6'd0;
      r_funct   <= 6'd0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_op    <= opcode;
        r_funct <= funct;
      end
      if (w_illegal_set) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_illegal_set = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    npc_sel       = 1'b0;
    j_ctl         = 1'b0;
    alu_ctl       = 2'b00;
    alu_src       = 1'b0;
    ext_op        = 2'b00;
    reg_dst       = 1'b0;
    reg_src       = 2'b00;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    ins_done      = 1'b0;
    illegal       = r_illegal & ~rst;
    // Reset blanks every enable so an aborted instruction cannot commit
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          ir_write     = 1'b1;
          pc_write     = (PC_INC_EN_FETCH != 0);
          w_next_state = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_ADDU || funct == FN_SUBU) begin
                w_next_state = S_EXE;
              end else begin
                w_next_state  = S_FETCH;
                w_illegal_set = 1'b1;
              end
            end
            OP_ORI, OP_LW, OP_SW: w_next_state = S_EXE;
            OP_LUI:               w_next_state = S_WB;
            OP_BEQ:               w_next_state = S_BRANCH;
            OP_J:                 w_next_state = S_JUMP;
            default: begin
              w_next_state  = S_FETCH;
              w_illegal_set = 1'b1;
            end
          endcase
        end
        S_EXE: begin
          alu_src      = w_is_ori | w_is_lw | w_is_sw;
          alu_ctl      = w_is_subu ? 2'b01 : (w_is_ori ? 2'b10 : 2'b00);
          ext_op       = (w_is_lw | w_is_sw) ? 2'b01 : 2'b00;
          w_next_state = (w_is_lw | w_is_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (w_is_sw) begin
            mem_write    = 1'b1;
            ins_done     = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end
        S_WB: begin
          reg_write    = 1'b1;
          reg_dst      = w_is_r;
          reg_src      = w_is_lw ? 2'b01 : (w_is_lui ? 2'b10 : 2'b00);
          ext_op       = w_is_lui ? 2'b10 : 2'b00;
          ins_done     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_ctl      = 2'b01;
          pc_write     = zero;
          npc_sel      = 1'b1;
          ext_op       = 2'b01;
          ins_done     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_write     = 1'b1;
          j_ctl        = 1'b1;
          ins_done     = 1'b1;
          w_next_state = S_FETCH;
        end
        default: w_next_state = S_FETCH;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (ins_done) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle tables plus randomized instruction streams.
// Counter checks are included when MC_CTRL_PERF_EN is defined.
module tb_mc_ctrl;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       npc_sel;
    logic       j_ctl;
    logic [1:0] alu_ctl;
    logic       alu_src;
    logic [1:0] ext_op;
    logic       reg_dst;
    logic [1:0] reg_src;
    logic       reg_write;
    logic       mem_write;
    logic       ins_done;
  } out_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic ir_write, pc_write, npc_sel, j_ctl, alu_src, reg_dst, reg_write, mem_write, ins_done, illegal;
  logic [1:0] alu_ctl, ext_op, reg_src;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  out_t got;

  int errors = 0;
  int checks = 0;
  logic m_illegal = 1'b0;
  int unsigned m_cyc = 0;
  int unsigned m_instr = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .npc_sel(npc_sel), .j_ctl(j_ctl),
    .alu_ctl(alu_ctl), .alu_src(alu_src), .ext_op(ext_op), .reg_dst(reg_dst),
    .reg_src(reg_src), .reg_write(reg_write), .mem_write(mem_write),
    .ins_done(ins_done), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign got = {ir_write, pc_write, npc_sel, j_ctl, alu_ctl, alu_src, ext_op,
                reg_dst, reg_src, reg_write, mem_write, ins_done};

  // Cycles each instruction occupies, from the instruction set table
  function automatic int cpi(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:                return (fn == F_ADDU || fn == F_SUBU) ? 4 : 2;
      OP_ORI, OP_SW:       return 4;
      OP_LW:               return 5;
      OP_LUI, OP_BEQ, OP_J: return 3;
      default:             return 2;
    endcase
  endfunction

  // Expected control vector for cycle k (0 = fetch, 1 = decode) of an instruction
  function automatic out_t model(input logic [5:0] op, input logic [5:0] fn, input int k, input logic z);
    out_t o;
    o = '0;
    if (k == 0) begin
      o.ir_write = 1'b1;
      o.pc_write = 1'b1;
    end else if (k >= 2) begin
      case (op)
        OP_R: if (k == 2) o.alu_ctl = (fn == F_SUBU) ? 2'b01 : 2'b00;
              else begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.ins_done = 1'b1; end
        OP_ORI: if (k == 2) begin o.alu_src = 1'b1; o.alu_ctl = 2'b10; end
                else begin o.reg_write = 1'b1; o.ins_done = 1'b1; end
        OP_LW: if (k == 2) begin o.alu_src = 1'b1; o.ext_op = 2'b01; end
               else if (k == 4) begin o.reg_write = 1'b1; o.reg_src = 2'b01; o.ins_done = 1'b1; end
        OP_SW: if (k == 2) begin o.alu_src = 1'b1; o.ext_op = 2'b01; end
               else begin o.mem_write = 1'b1; o.ins_done = 1'b1; end
        OP_LUI: begin o.reg_write = 1'b1; o.reg_src = 2'b10; o.ext_op = 2'b10; o.ins_done = 1'b1; end
        OP_BEQ: begin
          o.alu_ctl = 2'b01; o.pc_write = z; o.npc_sel = 1'b1; o.ext_op = 2'b01; o.ins_done = 1'b1;
        end
        OP_J: begin o.pc_write = 1'b1; o.j_ctl = 1'b1; o.ins_done = 1'b1; end
        default: o = '0;
      endcase
    end
    return o;
  endfunction

  task automatic tick(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct = fn; zero = z;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
      checks++;
      if (got !== '0 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got out=%h illegal=%b, expected out=0 illegal=0", i, got, illegal);
      end
    end
    m_illegal = 1'b0;
    m_cyc = 0;
    m_instr = 0;
  endtask

  // Runs one instruction cycle by cycle; abort_k >= 0 asserts rst in that cycle instead
  task automatic exec(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input int abort_k);
    int n;
    logic zk;
    out_t exp;
    n = cpi(op, fn);
    for (int k = 0; k < n; k++) begin
      zk = (k == 2) ? z : 1'($urandom);
      if (k == abort_k) begin
        tick(1'b1, 6'($urandom), 6'($urandom), zk);
        checks++;
        if (got !== '0 || illegal !== 1'b0) begin
          errors++;
          $display("FAIL %s abort cyc%0d: got out=%h illegal=%b, expected out=0 illegal=0", name, k, got, illegal);
        end
        m_illegal = 1'b0; m_cyc = 0; m_instr = 0;
        return;
      end
      if (k == 1) tick(1'b0, op, fn, zk);
      else        tick(1'b0, 6'($urandom), 6'($urandom), zk);
      exp = model(op, fn, k, zk);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d outputs: got %h expected %h", name, k, got, exp);
      end
      checks++;
      if (illegal !== m_illegal) begin
        errors++;
        $display("FAIL %s cyc%0d illegal: got %b expected %b", name, k, illegal, m_illegal);
      end
`ifdef MC_CTRL_PERF_EN
      checks++;
      if (cycle_cnt !== m_cyc || instr_cnt !== m_instr) begin
        errors++;
        $display("FAIL %s cyc%0d counters: got %0d/%0d expected %0d/%0d", name, k,
                 cycle_cnt, instr_cnt, m_cyc, m_instr);
      end
`endif
      m_cyc++;
      if (exp.ins_done) m_instr++;
      if (k == 1 && n == 2) m_illegal = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_addu();
    exec("addu", OP_R, F_ADDU, 1'b0, -1);
  endtask

  task automatic test_lw_sw();
    exec("lw", OP_LW, 6'($urandom), 1'b0, -1);
    exec("sw", OP_SW, 6'($urandom), 1'b0, -1);
  endtask

  task automatic test_beq();
    exec("beq_taken", OP_BEQ, 6'($urandom), 1'b1, -1);
    exec("beq_not_taken", OP_BEQ, 6'($urandom), 1'b0, -1);
  endtask

  task automatic test_other_ops();
    exec("subu", OP_R, F_SUBU, 1'b0, -1);
    exec("ori", OP_ORI, 6'($urandom), 1'b0, -1);
    exec("lui", OP_LUI, 6'($urandom), 1'b0, -1);
    exec("j", OP_J, 6'($urandom), 1'b0, -1);
  endtask

  task automatic test_illegal();
    exec("illegal_op", 6'b111111, 6'($urandom), 1'b0, -1);
    exec("after_illegal_addu", OP_R, F_ADDU, 1'b0, -1);
    exec("illegal_funct", OP_R, 6'b000000, 1'b0, -1);
    exec("after_illegal_lw", OP_LW, 6'd0, 1'b0, -1);
    do_reset(2);
    exec("post_reset_ori", OP_ORI, 6'd0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_lw();
    exec("lw_abort", OP_LW, 6'd0, 1'b0, 3);
    exec("after_abort_sw", OP_SW, 6'd0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    for (int i = 0; i < 60; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 8))
        0: begin op = OP_R; fn = F_ADDU; end
        1: begin op = OP_R; fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : F_SUBU; end
        2: op = OP_ORI;
        3: op = OP_LW;
        4: op = OP_SW;
        5: op = OP_BEQ;
        6: op = OP_LUI;
        7: op = OP_J;
        default: op = 6'($urandom);
      endcase
      exec("random", op, fn, 1'($urandom), -1);
      if (i == 30) do_reset(1);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_sw();
    test_beq();
    test_other_ops();
    test_illegal();
    test_reset_mid_lw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
